// File: rtl/ifu_prefetch.sv
// Decoupled instruction fetch front end: one-outstanding memory requester feeding a DEPTH-entry prefetch queue, with redirect/flush.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned fetch_pc queues a single fault marker and halts fetch until the next redirect.
module ifu_prefetch #(
  parameter int              INST_WIDTH = 32,
  parameter int              PC_WIDTH   = 64,
  parameter int              DATA_WIDTH = 64,
  parameter int              DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 64'h0000000080000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PC_WIDTH-1:0]   mem_req_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  inst_fault
);

  localparam int LANES     = DATA_WIDTH / INST_WIDTH;
  localparam int LANE_LO   = $clog2(INST_WIDTH / 8);
  localparam int LANE_HI   = $clog2(DATA_WIDTH / 8);
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state_reg, state_next;
  logic [PC_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
  logic [PC_WIDTH-1:0]   req_pc_reg, req_pc_next;
  logic                  stale_reg, stale_next;
  logic                  halted_reg, halted_next;
  logic [CNT_W-1:0]      count_reg;
  logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;

  logic [INST_WIDTH-1:0] q_inst  [DEPTH];
  logic [PC_WIDTH-1:0]   q_pc    [DEPTH];
  logic                  q_fault [DEPTH];

  logic                  handshake, outstanding, credit, misaligned;
  logic                  push, do_pop, flush;
  logic [INST_WIDTH-1:0] push_inst;
  logic [PC_WIDTH-1:0]   push_pc;
  logic                  push_fault;

  // Split the response beat into instruction lanes, selected by the request address
  logic [INST_WIDTH-1:0] lane_word [LANES];
  logic [LANE_BITS-1:0]  lane_sel;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_word
    assign lane_word[gi] = mem_resp_data[gi*INST_WIDTH +: INST_WIDTH];
  end

  if (LANES > 1) begin : g_lane_sel
    assign lane_sel = req_pc_reg[LANE_HI-1:LANE_LO];
  end else begin : g_lane_single
    assign lane_sel = '0;
  end

`ifdef IFU_MISALIGN_CHECK_EN
  if (LANE_LO > 0) begin : g_misalign
    assign misaligned = |fetch_pc_reg[LANE_LO-1:0];
  end else begin : g_no_misalign
    assign misaligned = 1'b0;
  end
`else
  assign misaligned = 1'b0;
`endif

  // Requests are held back while a flushed response is still due, keeping one in flight
  assign mem_req_valid = (state_reg == REQ) && !stale_reg && !misaligned;
  assign mem_req_addr  = fetch_pc_reg;
  assign handshake     = mem_req_valid && mem_req_ready;
  assign outstanding   = (state_reg == WAIT) || ((state_reg == REQ) && handshake);
  assign credit        = ((CNT_W+1)'(count_reg) + (CNT_W+1)'(outstanding)) < (CNT_W+1)'(DEPTH);

  assign inst_valid = (count_reg != '0);
  assign inst       = inst_valid ? q_inst[rd_ptr_reg]  : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr_reg]    : '0;
  assign inst_fault = inst_valid ? q_fault[rd_ptr_reg] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
      stale_reg    <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      stale_reg    <= stale_next;
      halted_reg   <= halted_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    halted_next   = halted_reg;
    stale_next    = stale_reg && !mem_resp_valid;
    push          = 1'b0;
    push_inst     = lane_word[lane_sel];
    push_pc       = req_pc_reg;
    push_fault    = 1'b0;
    do_pop        = inst_ready && inst_valid;
    flush         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (credit && !halted_reg) state_next = REQ;
      end
      REQ: begin
        if (misaligned) begin
          if (credit) begin
            push        = 1'b1;
            push_inst   = '0;
            push_pc     = fetch_pc_reg;
            push_fault  = 1'b1;
            halted_next = 1'b1;
            state_next  = IDLE;
          end
        end else if (handshake) begin
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + PC_WIDTH'(4);
          state_next    = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid && !stale_reg) begin
          push       = 1'b1;
          state_next = credit ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect wins: a response completing this cycle is simply dropped, anything still in flight goes stale
    if (redirect_valid) begin
      flush         = 1'b1;
      push          = 1'b0;
      do_pop        = 1'b0;
      fetch_pc_next = redirect_pc;
      halted_next   = 1'b0;
      state_next    = REQ;
      stale_next    = (stale_reg && !mem_resp_valid)
                   || ((state_reg == WAIT) && !mem_resp_valid)
                   || ((state_reg == REQ) && handshake);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else if (flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (push)   wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr_reg]  <= push_inst;
      q_pc[wr_ptr_reg]    <= push_pc;
      q_fault[wr_ptr_reg] <= push_fault;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: latency-configurable memory model plus an expected-instruction queue refilled on every redirect/reset.
module tb_ifu_prefetch;

  localparam logic [63:0] RESET_PC = 64'h0000000080000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    int          due;
  } pend_t;

  exp_t  sb[$];
  pend_t pend[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int hs_count = 0;
  int delivered = 0;
  bit hs_flag  = 0;
  logic [63:0] req_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [63:0] mk_data(input logic [63:0] a);
    logic [63:0] b;
    b = a & ~64'h7;
    return {word_at(b + 64'd4), word_at(b)};
  endfunction

  // Expected decode stream after a (re)start at pc
  task automatic load_run(input logic [63:0] pc);
    sb.delete();
`ifdef IFU_MISALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      sb.push_back('{pc: pc, inst: 32'h0, fault: 1'b1});
      return;
    end
`endif
    for (int k = 0; k < 64; k++)
      sb.push_back('{pc: pc + 64'(4*k), inst: word_at((pc & ~64'h3) + 64'(4*k)), fault: 1'b0});
  endtask

  // One clock: drive memory response, account handshake/delivery/redirect, advance to next negedge
  task automatic cycle();
    bit   resp_now;
    exp_t e;
    resp_now = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mk_data(pend[0].addr);
      resp_now = 1;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    #1;
    hs_flag = 0;
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, req_exp);
        req_exp = req_exp + 64'd4;
        pend.push_back('{addr: mem_req_addr, due: cyc + mem_lat});
        hs_count++;
        hs_flag = 1;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(inst_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          $display("deliver pc=0x%0h inst=0x%08h fault=%0b", inst_pc, inst, inst_fault);
          check("inst_pc", inst_pc, e.pc);
          check("inst", 64'(inst), 64'(e.inst));
          check("inst_fault", 64'(inst_fault), 64'(e.fault));
          delivered++;
        end
      end
      if (redirect_valid) begin
        load_run(redirect_pc);
        req_exp = redirect_pc;
      end
    end
    if (resp_now) void'(pend.pop_front());
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_handshake(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = hs_flag;
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_req_addr"}, mem_req_addr, RESET_PC);
    check({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    check({tag, "_inst"}, 64'(inst), 64'd0);
    check({tag, "_inst_pc"}, inst_pc, 64'd0);
    check({tag, "_inst_fault"}, 64'(inst_fault), 64'd0);
  endtask

  initial begin
    bit found;
    // Reset values and start-up latency
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    load_run(RESET_PC);
    req_exp = RESET_PC;
    rst = 1'b0;
    check("first_cycle_idle", 64'(mem_req_valid), 64'd0);
    cycle();
    check("req_after_idle", 64'(mem_req_valid), 64'd1);
    check("req_addr_reset_pc", mem_req_addr, RESET_PC);

    // Sequential fetch, single-cycle memory, decode always ready
    delivered = 0;
    run(20);
    check("throughput", 64'(delivered >= 9), 64'd1);

    // Queue fills to DEPTH with decode stalled, then one pop frees exactly one request
    inst_ready = 1'b0;
    do_redirect(64'h0000000080000100);
    hs_count = 0;
    run(20);
    check("fill_requests", 64'(hs_count), 64'd4);
    check("fill_req_idle", 64'(mem_req_valid), 64'd0);
    check("fill_inst_valid", 64'(inst_valid), 64'd1);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    hs_count = 0;
    run(10);
    check("one_pop_one_req", 64'(hs_count), 64'd1);
    inst_ready = 1'b1;
    run(20);

    // Redirect while WAITing on a 2-cycle memory: the in-flight response must be dropped
    mem_lat = 2;
    wait_handshake("wait_hs_redirect");
    do_redirect(64'h0000000080001000);
    check("redir_wait_empty", 64'(inst_valid), 64'd0);
    run(20);
    mem_lat = 1;
    run(4);

    // Redirect coinciding with a pop and a push
    inst_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (inst_valid && pend.size() > 0 && pend[0].due <= cyc) found = 1;
      else cycle();
    end
    check("found_push_pop", 64'(found), 64'd1);
    inst_ready = 1'b1;
    do_redirect(64'h0000000080003000);
    check("flush_inst_valid", 64'(inst_valid), 64'd0);
    check("flush_req_valid", 64'(mem_req_valid), 64'd1);
    check("flush_req_addr", mem_req_addr, 64'h0000000080003000);
    run(14);

    // Memory back-pressure: request held stable
    mem_req_ready = 1'b0;
    run(3);
    do_redirect(64'h0000000080002000);
    for (int i = 0; i < 5; i++) begin
      check("stall_req_valid", 64'(mem_req_valid), 64'd1);
      check("stall_req_addr", mem_req_addr, 64'h0000000080002000);
      cycle();
    end
    mem_req_ready = 1'b1;
    run(12);

    // Asynchronous reset in the middle of WAIT
    mem_lat = 2;
    wait_handshake("wait_hs_reset");
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    pend.delete();
    load_run(RESET_PC);
    req_exp = RESET_PC;
    cycle();
    rst = 1'b0;
    mem_lat = 1;
    check("rst_first_idle", 64'(mem_req_valid), 64'd0);
    cycle();
    check("rst_refetch_valid", 64'(mem_req_valid), 64'd1);
    check("rst_refetch_addr", mem_req_addr, RESET_PC);
    run(12);

    // Halfword-offset redirect
    do_redirect(64'h0000000080000002);
    hs_count = 0;
    run(10);
`ifdef IFU_MISALIGN_CHECK_EN
    check("misalign_no_req", 64'(hs_count), 64'd0);
    check("misalign_one_entry", 64'(sb.size()), 64'd0);
    check("misalign_idle", 64'(mem_req_valid), 64'd0);
`else
    check("unaligned_fetches", 64'(hs_count > 0), 64'd1);
`endif
    do_redirect(64'h0000000080000000);
    hs_count = 0;
    run(12);
    check("resume_fetch", 64'(hs_count > 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
